// File: rtl/round_sequencer.sv
// One play round: spawns objects in random lanes, steps them down the rows,
// judges catch/miss at the bottom row and keeps score/miss with a shrinking fall period.
module round_sequencer #(
  parameter int STEP_CYCLES = 25_000_000,
  parameter int STEP_MIN    = 6_250_000,
  parameter int STEP_DEC    = 1_250_000,
  parameter int ROWS        = 12,
  parameter int GAP_STEPS   = 2,
  parameter int MAX_OBJ     = 10,
  parameter int MISS_LIMIT  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic [1:0] catch_dir,
  output logic       obj_valid,
  output logic [1:0] obj_lane,
  output logic [3:0] obj_row,
  output logic [3:0] score,
  output logic [3:0] miss,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       round_done
);

  localparam int CW = $clog2(STEP_CYCLES + 1);
  localparam int GW = (GAP_STEPS > 1) ? $clog2(GAP_STEPS) : 1;

  localparam logic [CW-1:0] PER_INIT  = CW'(STEP_CYCLES);
  localparam logic [CW-1:0] PER_MIN   = CW'(STEP_MIN);
  localparam logic [CW-1:0] PER_DEC   = CW'(STEP_DEC);
  localparam logic [3:0]    ROW_LAST  = 4'(ROWS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_STEPS - 1);
  localparam logic [4:0]    OBJ_LIMIT = 5'(MAX_OBJ);
  localparam logic [3:0]    MISS_LIM  = 4'(MISS_LIMIT);

  typedef enum logic [2:0] {IDLE, SPAWN, FALL, JUDGE, GAP, DONE} fsm_t;

  fsm_t          fsm;
  logic [7:0]    lfsr;
  logic [CW-1:0] step_cnt;
  logic [CW-1:0] period;
  logic [GW-1:0] gap_cnt;

  logic       play;
  logic       clear;
  logic       step_wrap;
  logic       judge_hit;
  logic [3:0] score_next;
  logic [3:0] miss_next;
  logic       judge_end;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Compared one bit wider so the floor test itself cannot overflow or underflow.
  function automatic logic [CW-1:0] next_period(input logic [CW-1:0] p);
    if ({1'b0, p} >= ({1'b0, PER_MIN} + {1'b0, PER_DEC}))
      return p - PER_DEC;
    else
      return PER_MIN;
  endfunction

  assign play       = (state == 3'b010);
  assign clear      = (state == 3'b000) || (state == 3'b001);
  assign step_wrap  = (step_cnt == period - 1'b1);
  assign judge_hit  = (catch_dir == obj_lane);
  assign score_next = judge_hit ? sat_inc(score) : score;
  assign miss_next  = judge_hit ? miss : sat_inc(miss);
  assign judge_end  = (({1'b0, score_next} + {1'b0, miss_next}) == OBJ_LIMIT) ||
                      (miss_next == MISS_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm        <= IDLE;
      lfsr       <= 8'hA5;
      step_cnt   <= '0;
      period     <= PER_INIT;
      gap_cnt    <= '0;
      obj_valid  <= 1'b0;
      obj_lane   <= 2'd0;
      obj_row    <= 4'd0;
      score      <= 4'd0;
      miss       <= 4'd0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      round_done <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (clear) begin
        fsm        <= IDLE;
        step_cnt   <= '0;
        period     <= PER_INIT;
        gap_cnt    <= '0;
        obj_valid  <= 1'b0;
        obj_lane   <= 2'd0;
        obj_row    <= 4'd0;
        score      <= 4'd0;
        miss       <= 4'd0;
        round_done <= 1'b0;
      end else if (play) begin
        // Any non-play, non-clear state code simply skips this branch: full freeze.
        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        case (fsm)
          IDLE: fsm <= SPAWN;
          SPAWN: begin
            obj_lane  <= lfsr[1:0];
            obj_row   <= 4'd0;
            obj_valid <= 1'b1;
            step_cnt  <= '0;
            fsm       <= FALL;
          end
          FALL: begin
            if (step_wrap) begin
              step_cnt <= '0;
              if (obj_row < ROW_LAST) obj_row <= obj_row + 4'd1;
              else                    fsm     <= JUDGE;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
          JUDGE: begin
            score      <= score_next;
            miss       <= miss_next;
            hit_pulse  <= judge_hit;
            miss_pulse <= !judge_hit;
            if (judge_hit) period <= next_period(period);
            obj_valid  <= 1'b0;
            step_cnt   <= '0;
            gap_cnt    <= '0;
            if (judge_end) begin
              fsm        <= DONE;
              round_done <= 1'b1;
            end else begin
              fsm <= GAP;
            end
          end
          GAP: begin
            if (step_wrap) begin
              step_cnt <= '0;
              if (gap_cnt == GAP_LAST) fsm     <= SPAWN;
              else                     gap_cnt <= gap_cnt + 1'b1;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
          DONE:    round_done <= 1'b1;
          default: fsm <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: scoreboard of judge outcomes queued at each spawn,
// plus lane (LFSR) and per-row fall-period checks from an independent model.
module tb_round_sequencer;

  localparam int SC = 4;
  localparam int SM = 2;
  localparam int SD = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] state = 3'b000;
  logic [1:0] catch_dir = 2'd0;
  logic       obj_valid;
  logic [1:0] obj_lane;
  logic [3:0] obj_row;
  logic [3:0] score;
  logic [3:0] miss;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       round_done;

  always #5 clk = ~clk;

  round_sequencer #(
    .STEP_CYCLES(SC), .STEP_MIN(SM), .STEP_DEC(SD), .ROWS(4),
    .GAP_STEPS(1), .MAX_OBJ(3), .MISS_LIMIT(2)
  ) dut (
    .clk(clk), .rst(rst), .state(state), .catch_dir(catch_dir),
    .obj_valid(obj_valid), .obj_lane(obj_lane), .obj_row(obj_row),
    .score(score), .miss(miss), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .round_done(round_done)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    bit hit;
    int score;
    int miss;
    bit done;
  } exp_t;

  exp_t       sb[$];
  int         exp_score = 0;
  int         exp_miss  = 0;
  int         exp_period = SC;
  bit         mode = 1'b0;  // 0: catcher follows the object, 1: catcher always elsewhere
  logic [7:0] lfsr_m = 8'hA5;
  logic [7:0] lfsr_prev = 8'hA5;
  bit         prev_valid = 1'b0;
  bit         prev_hit = 1'b0;
  logic [3:0] prev_row = 4'd0;
  int         run_cnt = 0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(negedge clk) catch_dir = mode ? ~obj_lane : obj_lane;

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!rst) begin
      exp_score = 0; exp_miss = 0; exp_period = SC;
      sb.delete();
      lfsr_m = 8'hA5; lfsr_prev = 8'hA5;
      prev_valid = 1'b0; prev_hit = 1'b0; prev_row = 4'd0;
    end else begin
      lfsr_prev = lfsr_m;
      if (state == 3'b010) lfsr_m = lfsr_step(lfsr_m);
      if (state == 3'b000 || state == 3'b001) begin
        exp_score = 0; exp_miss = 0; exp_period = SC;
        sb.delete();
      end
      if (obj_valid && !prev_valid) begin
        check("spawn_lane", obj_lane, lfsr_prev[1:0]);
        check("spawn_row", obj_row, 0);
        run_cnt = 0;
        e.hit = !mode;
        if (e.hit) exp_score = (exp_score < 15) ? exp_score + 1 : 15;
        else       exp_miss  = (exp_miss  < 15) ? exp_miss  + 1 : 15;
        e.score = exp_score;
        e.miss  = exp_miss;
        e.done  = (exp_score + exp_miss == 3) || (exp_miss == 2);
        sb.push_back(e);
      end else if (obj_valid && prev_valid && state == 3'b010) begin
        run_cnt++;
        if (obj_row != prev_row) begin
          check("row_step", obj_row, prev_row + 4'd1);
          check("row_period", run_cnt, exp_period);
          run_cnt = 0;
        end
      end
      if (hit_pulse || miss_pulse) begin
        check("pulse_excl", hit_pulse & miss_pulse, 0);
        if (hit_pulse) check("hit_width", prev_hit, 0);
        check("sb_depth", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("hit_pulse", hit_pulse, e.hit);
          check("miss_pulse", miss_pulse, !e.hit);
          check("score", score, e.score);
          check("miss", miss, e.miss);
          check("round_done", round_done, e.done);
          if (e.hit) exp_period = (exp_period - SD > SM) ? exp_period - SD : SM;
        end
      end
      prev_valid = obj_valid;
      prev_hit   = hit_pulse;
      prev_row   = obj_row;
    end
  end

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!round_done && n < budget) begin
      @(posedge clk); #3; n++;
    end
    check(tag, round_done, 1);
  endtask

  task automatic wait_row(input logic [3:0] r, input int budget, input string tag);
    int n = 0;
    while (!(obj_valid && obj_row == r) && n < budget) begin
      @(posedge clk); #3; n++;
    end
    check(tag, obj_valid && obj_row == r, 1);
  endtask

  task automatic wait_pulse(input int budget, output int n);
    n = 0;
    while (!(hit_pulse || miss_pulse) && n < budget) begin
      @(posedge clk); #3; n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen_valid;
    repeat (2) @(negedge clk);
    check("rst_valid", obj_valid, 0);
    check("rst_outs", {obj_lane, obj_row, score, miss, hit_pulse, miss_pulse, round_done}, 0);

    // Round 1: catcher follows every object.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) state = 3'b010;
    @(posedge clk) #3 check("spawn_lat0", obj_valid, 0);
    @(posedge clk) #3 check("spawn_lat1", obj_valid, 1);
    check("first_lane", obj_lane, 2);
    wait_row(4'd3, 40, "reach_row3");
    wait_pulse(20, n);
    check("judge_lat", n, 5);
    check("first_hit", hit_pulse, 1);
    wait_done(400, "done_all_catch");
    check("final_score", score, 3);
    check("final_miss", miss, 0);
    repeat (20) @(posedge clk);
    #3;
    check("done_no_spawn", obj_valid, 0);
    check("done_held", round_done, 1);
    check("done_score_held", score, 3);

    // Clear from DONE, then a round where every object is missed.
    @(negedge clk) state = 3'b001;
    @(posedge clk) #3;
    check("clr_score", score, 0);
    check("clr_miss", miss, 0);
    check("clr_done", round_done, 0);
    @(negedge clk) begin mode = 1'b1; state = 3'b010; end
    @(posedge clk) #3 check("spawn2_lat0", obj_valid, 0);
    @(posedge clk) #3 check("spawn2_lat1", obj_valid, 1);
    wait_done(400, "done_all_miss");
    check("miss_round_miss", miss, 2);
    check("miss_round_score", score, 0);
    seen_valid = 1'b0;
    repeat (30) begin
      @(posedge clk); #3;
      if (obj_valid) seen_valid = 1'b1;
    end
    check("no_third_spawn", seen_valid, 0);

    // Pause in the middle of row 2, then resume.
    @(negedge clk) begin mode = 1'b0; state = 3'b001; end
    @(negedge clk) state = 3'b010;
    wait_row(4'd2, 40, "reach_row2");
    @(negedge clk);
    @(negedge clk) state = 3'b101;
    repeat (20) @(negedge clk);
    check("pause_row", obj_row, 2);
    check("pause_valid", obj_valid, 1);
    state = 3'b010;
    wait_row(4'd3, 20, "resume_row3");
    wait_pulse(40, n);
    check("pause_round_hit", hit_pulse, 1);
    check("pause_round_score", score, 1);

    // Asynchronous reset while in the gap between objects.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_score", score, 0);
    check("async_rst_outs", {obj_valid, obj_lane, obj_row, miss, hit_pulse, miss_pulse, round_done}, 0);
    @(negedge clk) state = 3'b000;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) state = 3'b010;
    wait_row(4'd1, 40, "post_rst_row1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
